reaction_game_fsm: RTL and testbench
====================================

Name: reaction_game_fsm

Overview:
Parametrised multi-player reaction-game controller, the next generation of the two-player game logic FSM. It arms a round, waits a delay, then asserts a GO light. The first player to press after GO scores; a press before GO is a foul. It keeps per-player scores, declares a winner at a target score, and drives the display and status outputs consumed by the display driver.

Parameters:
NUM_PLAYERS, 2, number of player inputs (2..8)
SCORE_W, 4, width of each player's score counter
WIN_SCORE, 5, score that ends the match (must be < 2**SCORE_W)
DELAY_CYCLES, 50000000, cycles from round arm to GO (>= 1)
TIMEOUT_CYCLES, 100000000, cycles GO stays up with no press before the round is abandoned (>= 1)
HOLD_CYCLES, 50000000, cycles a round result is displayed (>= 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  level; starts a match from IDLE or DONE
pdata  input  NUM_PLAYERS  player buttons, already synchronised and debounced, active-high
go  output  1  GO light
score  output  NUM_PLAYERS*SCORE_W  packed scores; player i at bits [i*SCORE_W +: SCORE_W]
last  output  NUM_PLAYERS  one-hot player credited or penalised in the last round; 0 if none
foul  output  1  last round ended in a foul
winner  output  NUM_PLAYERS  one-hot match winner; valid in DONE only
state_o  output  3  state code for the display driver

Behaviour:
- Reset is synchronous, active-low, and wins over everything including mid-round. On reset: state=IDLE, go=0, score=0, last=0, foul=0, winner=0, all counters=0, press-history register=0.
- Press detection:
  - prev <= pdata every cycle.
  - press = pdata & ~prev, so only rising edges count. Holding a button never re-scores.
  - If several bits of press are set in the same cycle, the lowest index wins.
- All outputs are registered. A state change takes effect one cycle after its cause is sampled.
- State codes: IDLE=0, WAIT=1, GO=2, SHOW=3, DONE=4.
- IDLE:
  - On start=1: go to WAIT, load cnt=DELAY_CYCLES-1, clear last and foul.
- WAIT:
  - If press is nonzero: this is a foul. The offender's score decrements, saturating at 0. Set last to the offender one-hot and foul=1, then go to SHOW with cnt=HOLD_CYCLES-1.
  - Otherwise, if cnt==0: go to GO, set go=1, load cnt=TIMEOUT_CYCLES-1.
  - Otherwise: decrement cnt.
  - Press takes priority over cnt==0 in the same cycle.
- GO:
  - If press is nonzero: the winning player's score increments, saturating at 2**SCORE_W-1. Set last to that player one-hot and foul=0, then go to SHOW.
  - Otherwise, if cnt==0: set last=0 and foul=0, then go to SHOW.
  - go drops to 0 on leaving GO.
- SHOW:
  - Count down HOLD_CYCLES.
  - At cnt==0: if any score >= WIN_SCORE, go to DONE and set winner to the one-hot of the lowest-index player with score >= WIN_SCORE. Otherwise go to WAIT, reload DELAY_CYCLES-1, and clear last and foul.
  - Presses in SHOW are ignored.
- DONE:
  - Scores, winner and last are held.
  - On start=1: clear score and winner, then go to WAIT exactly as from IDLE.
  - start is ignored in every other state.
- Counters are wide enough for max(DELAY,TIMEOUT,HOLD)-1 plus any LFSR addend.

Optional Feature:
Macro: REACTION_RANDOM_DELAY_EN
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every cycle.
  - On each WAIT load, cnt = DELAY_CYCLES-1 + lfsr[7:0]. The delay therefore varies over DELAY_CYCLES..DELAY_CYCLES+255.
- When undefined:
  - No LFSR is built, and the WAIT delay is exactly DELAY_CYCLES.

Test Plan:
(NUM_PLAYERS=2, DELAY=4, TIMEOUT=8, HOLD=2, WIN_SCORE=3, macro off)
1. Reset low for 2 cycles, then high, start=1 for 1 cycle -> state_o=1 next cycle; go=1 exactly 4 cycles after WAIT entry; score=0.
2. In GO, pdata=2'b10 rising -> next cycle state_o=3, score[7:4]=1, last=2'b10, foul=0; WAIT again 2 cycles later.
3. In WAIT, pdata=2'b01 rising while score[3:0]=0 -> foul=1, last=2'b01, score[3:0] stays 0 (saturation); GO never asserts that round.
4. In GO, pdata=2'b11 rising simultaneously -> player 0 credited (last=2'b01). Holding pdata high into the next GO round -> no score.
5. GO with no press for 8 cycles -> SHOW with last=0, scores unchanged. After player 1 reaches 3: DONE, state_o=4, winner=2'b10. start=1 -> scores 0, state_o=1.
6. Assert reset low mid-GO -> next cycle state_o=0, go=0, score=0, winner=0.

Source files
------------

// File: rtl/reaction_game_fsm.sv
// reaction_game_fsm: multi-player reaction game controller (arm, delay, GO, score, win).
// Define REACTION_RANDOM_DELAY_EN to add 0..255 cycles of LFSR jitter to each WAIT delay.
module reaction_game_fsm #(
  parameter int NUM_PLAYERS    = 2,
  parameter int SCORE_W        = 4,
  parameter int WIN_SCORE      = 5,
  parameter int DELAY_CYCLES   = 50000000,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int HOLD_CYCLES    = 50000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         pdata,
  output logic                           go,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         last,
  output logic                           foul,
  output logic [NUM_PLAYERS-1:0]         winner,
  output logic [2:0]                     state_o
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_SHOW = 3'd3,
    S_DONE = 3'd4
  } state_t;
`ifdef REACTION_RANDOM_DELAY_EN
  localparam int EXTRA = 255;
`else
  localparam int EXTRA = 0;
`endif
  localparam int MAX_DT = DELAY_CYCLES > TIMEOUT_CYCLES ? DELAY_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C  = (MAX_DT > HOLD_CYCLES ? MAX_DT : HOLD_CYCLES) - 1 + EXTRA;
  localparam int CW     = MAX_C > 0 ? $clog2(MAX_C + 1) : 1;
  localparam logic [CW-1:0] DELAY_LD   = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYCLES - 1);
  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d, wait_ld;
  logic                           go_q, go_d, foul_q, foul_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] score_q, score_d;
  logic [NUM_PLAYERS-1:0]         last_q, last_d, winner_q, winner_d, prev_q;
  logic [NUM_PLAYERS-1:0]         press, press_oh, win_oh;
  logic [SCORE_W-1:0]             cur;
  int                             press_idx;
`ifdef REACTION_RANDOM_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    wait_ld = DELAY_LD + CW'(lfsr_q[7:0]);
  end
`else
  always_comb wait_ld = DELAY_LD;
`endif
  // Rising-edge press detect; descending loops leave the lowest index as the winner.
  always_comb begin
    press     = pdata & ~prev_q;
    press_oh  = '0;
    press_idx = 0;
    win_oh    = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (press[i]) begin
        press_oh    = '0;
        press_oh[i] = 1'b1;
        press_idx   = i;
      end
      if (score_q[i*SCORE_W +: SCORE_W] >= SCORE_W'(WIN_SCORE)) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
    cur = score_q[press_idx*SCORE_W +: SCORE_W];
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    go_d     = go_q;
    score_d  = score_q;
    last_d   = last_q;
    foul_d   = foul_q;
    winner_d = winner_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_WAIT;
        cnt_d   = wait_ld;
        last_d  = '0;
        foul_d  = 1'b0;
        if (state_q == S_DONE) begin
          score_d  = '0;
          winner_d = '0;
        end
      end
      S_WAIT: if (|press) begin
        score_d[press_idx*SCORE_W +: SCORE_W] = cur - SCORE_W'(cur != '0);
        last_d  = press_oh;
        foul_d  = 1'b1;
        state_d = S_SHOW;
        cnt_d   = HOLD_LD;
      end else if (cnt_q == '0) begin
        state_d = S_GO;
        go_d    = 1'b1;
        cnt_d   = TIMEOUT_LD;
      end else cnt_d = cnt_q - CW'(1);
      S_GO: if (|press || cnt_q == '0) begin
        if (|press) score_d[press_idx*SCORE_W +: SCORE_W] = cur + SCORE_W'(cur != '1);
        last_d  = press_oh;
        foul_d  = 1'b0;
        go_d    = 1'b0;
        state_d = S_SHOW;
        cnt_d   = HOLD_LD;
      end else cnt_d = cnt_q - CW'(1);
      S_SHOW: if (cnt_q == '0) begin
        if (|win_oh) begin
          state_d  = S_DONE;
          winner_d = win_oh;
        end else begin
          state_d = S_WAIT;
          cnt_d   = wait_ld;
          last_d  = '0;
          foul_d  = 1'b0;
        end
      end else cnt_d = cnt_q - CW'(1);
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      go_q     <= 1'b0;
      score_q  <= '0;
      last_q   <= '0;
      foul_q   <= 1'b0;
      winner_q <= '0;
      prev_q   <= '0;
`ifdef REACTION_RANDOM_DELAY_EN
      lfsr_q   <= 16'hACE1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      go_q     <= go_d;
      score_q  <= score_d;
      last_q   <= last_d;
      foul_q   <= foul_d;
      winner_q <= winner_d;
      prev_q   <= pdata;
`ifdef REACTION_RANDOM_DELAY_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end
  assign go      = go_q;
  assign score   = score_q;
  assign last    = last_q;
  assign foul    = foul_q;
  assign winner  = winner_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_reaction_game_fsm.sv
// tb_reaction_game_fsm: directed scenarios plus randomized run against a behavioural game model.
module tb_reaction_game_fsm;
  localparam int DLY = 4, TMO = 8, HLD = 2, WIN = 3;
  logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] pdata = 2'b00;
  logic       go, foul;
  logic [7:0] score;
  logic [1:0] last, winner;
  logic [2:0] state_o;
  int checks = 0, errors = 0;

  reaction_game_fsm #(
    .NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(WIN),
    .DELAY_CYCLES(DLY), .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pdata(pdata), .go(go), .score(score),
    .last(last), .foul(foul), .winner(winner), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Game model: ph is the phase code, rem the cycles left in the phase including this one.
  typedef struct packed {
    int ph; int rem; int s0; int s1;
    logic [1:0] prev; logic [1:0] last; logic foul; logic [1:0] win;
  } mdl_t;
  mdl_t m;

  function automatic mdl_t nxt(mdl_t c, logic rn, logic st, logic [1:0] pd);
    mdl_t n;
    int s[2];
    int who;
    logic [1:0] pr;
    n = c;
    n.prev = pd;
    if (!rn) begin
      n = '0;
      return n;
    end
    s[0] = c.s0;
    s[1] = c.s1;
    pr = pd & ~c.prev;
    who = pr[0] ? 0 : (pr[1] ? 1 : -1);
    case (c.ph)
      0, 4: if (st) begin
        if (c.ph == 4) begin s[0] = 0; s[1] = 0; n.win = 2'b00; end
        n.ph = 1; n.rem = DLY; n.last = 2'b00; n.foul = 1'b0;
      end
      1: if (who >= 0) begin
        if (s[who] > 0) s[who] = s[who] - 1;
        n.last = (who == 0) ? 2'b01 : 2'b10; n.foul = 1'b1; n.ph = 3; n.rem = HLD;
      end else if (c.rem == 1) begin
        n.ph = 2; n.rem = TMO;
      end else n.rem = c.rem - 1;
      2: if (who >= 0) begin
        if (s[who] < 15) s[who] = s[who] + 1;
        n.last = (who == 0) ? 2'b01 : 2'b10; n.foul = 1'b0; n.ph = 3; n.rem = HLD;
      end else if (c.rem == 1) begin
        n.last = 2'b00; n.foul = 1'b0; n.ph = 3; n.rem = HLD;
      end else n.rem = c.rem - 1;
      3: if (c.rem == 1) begin
        if (s[0] >= WIN) begin n.ph = 4; n.win = 2'b01; end
        else if (s[1] >= WIN) begin n.ph = 4; n.win = 2'b10; end
        else begin n.ph = 1; n.rem = DLY; n.last = 2'b00; n.foul = 1'b0; end
      end else n.rem = c.rem - 1;
      default: n.ph = 0;
    endcase
    n.s0 = s[0];
    n.s1 = s[1];
    return n;
  endfunction

  always @(posedge clk) m <= nxt(m, reset, start, pdata);

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (state_o !== s && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_state: state_o=%0d never reached %0d", state_o, s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({state_o, go, score, last, foul, winner} !== 16'h0) begin
      errors++;
      $display("FAIL reset: state=%0d go=%b score=%h last=%b foul=%b winner=%b, want all 0",
               state_o, go, score, last, foul, winner);
    end
    reset = 1'b1;
  endtask

  task automatic test_start_delay();
    int n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL start_wait: state=%0d want 1", state_o); end
    while (go !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != DLY) begin errors++; $display("FAIL go_delay: go after %0d cycles want %0d", n, DLY); end
    checks++;
    if (score !== 8'h00) begin errors++; $display("FAIL start_score: score=%h want 00", score); end
  endtask

  task automatic test_go_press();
    pdata = 2'b10;
    @(negedge clk);
    pdata = 2'b00;
    checks++;
    if ({state_o, score[7:4], last, foul, go} !== {3'd3, 4'd1, 2'b10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL go_press: state=%0d s1=%0d last=%b foul=%b go=%b want 3 1 10 0 0",
               state_o, score[7:4], last, foul, go);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL show_hold: state=%0d want 1", state_o); end
  endtask

  task automatic test_foul();
    logic seen_go = 1'b0;
    pdata = 2'b01;
    @(negedge clk);
    pdata = 2'b00;
    checks++;
    if ({state_o, foul, last, score[3:0]} !== {3'd3, 1'b1, 2'b01, 4'd0}) begin
      errors++;
      $display("FAIL foul: state=%0d foul=%b last=%b s0=%0d want 3 1 01 0",
               state_o, foul, last, score[3:0]);
    end
    repeat (2) begin
      @(negedge clk);
      seen_go = seen_go | go;
    end
    checks++;
    if (seen_go !== 1'b0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL foul_round: go_seen=%b state=%0d want 0 1", seen_go, state_o);
    end
  endtask

  task automatic test_simultaneous_hold();
    wait_state(3'd2);
    pdata = 2'b11;
    @(negedge clk);
    checks++;
    if ({last, score} !== {2'b01, 8'h11}) begin
      errors++;
      $display("FAIL simultaneous: last=%b score=%h want 01 11", last, score);
    end
    wait_state(3'd2);
    repeat (TMO - 1) @(negedge clk);
    checks++;
    if (state_o !== 3'd2 || go !== 1'b1) begin
      errors++;
      $display("FAIL held_no_score: state=%0d go=%b want 2 1", state_o, go);
    end
    @(negedge clk);
    checks++;
    if ({state_o, go, last, foul, score} !== {3'd3, 1'b0, 2'b00, 1'b0, 8'h11}) begin
      errors++;
      $display("FAIL timeout: state=%0d go=%b last=%b foul=%b score=%h want 3 0 00 0 11",
               state_o, go, last, foul, score);
    end
    pdata = 2'b00;
  endtask

  task automatic test_win();
    repeat (2) begin
      wait_state(3'd2);
      pdata = 2'b10;
      @(negedge clk);
      pdata = 2'b00;
    end
    wait_state(3'd4);
    checks++;
    if ({winner, score, last} !== {2'b10, 8'h31, 2'b10}) begin
      errors++;
      $display("FAIL done: winner=%b score=%h last=%b want 10 31 10", winner, score, last);
    end
    pdata = 2'b11;
    repeat (3) @(negedge clk);
    pdata = 2'b00;
    checks++;
    if ({state_o, winner, score} !== {3'd4, 2'b10, 8'h31}) begin
      errors++;
      $display("FAIL done_hold: state=%0d winner=%b score=%h want 4 10 31", state_o, winner, score);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({state_o, score, winner} !== {3'd1, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL restart: state=%0d score=%h winner=%b want 1 00 00", state_o, score, winner);
    end
  endtask

  task automatic test_reset_mid_go();
    wait_state(3'd2);
    pdata = 2'b01;
    @(negedge clk);
    pdata = 2'b00;
    wait_state(3'd2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({state_o, go, score, winner, last, foul} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_go: state=%0d go=%b score=%h winner=%b last=%b foul=%b want 0",
               state_o, go, score, winner, last, foul);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (state_o !== m.ph[2:0] || go !== (m.ph == 2) || score !== {m.s1[3:0], m.s0[3:0]} ||
          last !== m.last || foul !== m.foul || winner !== m.win) begin
        errors++;
        $display("FAIL random[%0d]: state=%0d go=%b score=%h last=%b foul=%b win=%b want %0d %b %h %b %b %b",
                 i, state_o, go, score, last, foul, winner, m.ph, m.ph == 2,
                 {m.s1[3:0], m.s0[3:0]}, m.last, m.foul, m.win);
      end
      reset = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) pdata = 2'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_start_delay();
    test_go_press();
    test_foul();
    test_simultaneous_hold();
    test_win();
    test_reset_mid_go();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
